// File: rtl/regfile_pkg.sv
// Shared sizing and types for the register-file read port.
// Consumers import regfile_pkg::* for widths, index/data types and the zero-register index.
package regfile_pkg;

   localparam int DATA_W   = 64;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 31;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

   localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

endpackage

// File: rtl/regfile_read_port_if.sv
// Request/response handshake between decode, the read port and execute.
// master = decode/execute side, slave = the read port itself.
interface regfile_read_port_if;
   import regfile_pkg::*;

   logic      req_valid;
   logic      req_ready;
   reg_addr_t ra1;
   reg_addr_t ra2;
   logic      flush;
   logic      rsp_valid;
   logic      rsp_ready;
   reg_data_t rd1;
   reg_data_t rd2;

   modport master (
      output req_valid, ra1, ra2, flush, rsp_ready,
      input  req_ready, rsp_valid, rd1, rd2
   );

   modport slave (
      input  req_valid, ra1, ra2, flush, rsp_ready,
      output req_ready, rsp_valid, rd1, rd2
   );

endinterface

// File: rtl/regfile_read_mux.sv
// Combinational operand select: zero register, same-cycle write bypass, then the array.
// Addresses equal to the zero register never bypass because that check comes first.
module regfile_read_mux
   import regfile_pkg::*;
(
   input  logic [NUM_REGS*DATA_W-1:0] rf_q,
   input  logic                       wr_en,
   input  reg_addr_t                  wr_addr,
   input  reg_data_t                  wr_data,
   input  reg_addr_t                  addr,
   output reg_data_t                  data
);

   always_comb begin
      data = '0;
      if (addr == ZERO_ADDR) begin
         data = '0;
      end else if (wr_en && (wr_addr == addr)) begin
         data = wr_data;
      end else begin
         data = rf_q[DATA_W*int'(addr) +: DATA_W];
      end
   end

endmodule

// File: rtl/regfile_read_port.sv
// Register-file read port: one-cycle operand fetch over a valid/ready handshake.
// Define REGFILE_HOLD_BYPASS_EN to let stalled operands track writes to their source registers.
module regfile_read_port
   import regfile_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REGS*DATA_W-1:0] rf_q,
   input  logic                       wr_en,
   input  reg_addr_t                  wr_addr,
   input  reg_data_t                  wr_data,
   regfile_read_port_if.slave         rp
);

`ifdef REGFILE_HOLD_BYPASS_EN
   localparam bit HOLD_BYPASS = 1'b1;
`else
   localparam bit HOLD_BYPASS = 1'b0;
`endif

   logic      rsp_valid_q;
   reg_data_t rd1_q;
   reg_data_t rd2_q;
   reg_addr_t held_ra1;
   reg_addr_t held_ra2;
   reg_data_t sel1;
   reg_data_t sel2;
   logic      req_ready;
   logic      accept;
   logic      hold_hit1;
   logic      hold_hit2;

   regfile_read_mux u_mux1 (
      .rf_q    (rf_q),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .addr    (rp.ra1),
      .data    (sel1)
   );

   regfile_read_mux u_mux2 (
      .rf_q    (rf_q),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .addr    (rp.ra2),
      .data    (sel2)
   );

   assign req_ready = !rsp_valid_q || rp.rsp_ready;
   assign accept    = rp.req_valid && req_ready && !rp.flush;
   assign hold_hit1 = wr_en && (wr_addr == held_ra1) && (held_ra1 != ZERO_ADDR);
   assign hold_hit2 = wr_en && (wr_addr == held_ra2) && (held_ra2 != ZERO_ADDR);

   // Priority: reset, flush, accept, drain, then in-place update of a stalled response.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         held_ra1    <= '0;
         held_ra2    <= '0;
      end else if (rp.flush) begin
         rsp_valid_q <= 1'b0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rd1_q       <= sel1;
         rd2_q       <= sel2;
         held_ra1    <= rp.ra1;
         held_ra2    <= rp.ra2;
      end else if (rsp_valid_q && rp.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end else if (rsp_valid_q && HOLD_BYPASS) begin
         if (hold_hit1) begin
            rd1_q <= wr_data;
         end
         if (hold_hit2) begin
            rd2_q <= wr_data;
         end
      end
   end

   assign rp.req_ready = req_ready;
   assign rp.rsp_valid = rsp_valid_q;
   assign rp.rd1       = rd1_q;
   assign rp.rd2       = rd2_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: vector table plus hand sequences, checked against a response scoreboard.
// Honours REGFILE_HOLD_BYPASS_EN the same way the design does.
module tb_regfile_read_port;
   import regfile_pkg::*;

`ifdef REGFILE_HOLD_BYPASS_EN
   localparam bit HOLD_BYPASS = 1'b1;
`else
   localparam bit HOLD_BYPASS = 1'b0;
`endif

   typedef struct packed {
      reg_data_t rd1;
      reg_data_t rd2;
   } rsp_t;

   typedef struct {
      reg_addr_t a1;
      reg_addr_t a2;
      logic      we;
      reg_addr_t wa;
      reg_data_t wd;
      reg_data_t e1;
      reg_data_t e2;
   } vec_t;

   logic                       clk;
   logic                       reset;
   logic [NUM_REGS*DATA_W-1:0] rf_q;
   logic                       wr_en;
   reg_addr_t                  wr_addr;
   reg_data_t                  wr_data;
   reg_data_t                  regs [NUM_REGS];

   int        n_tests;
   int        n_fail;
   logic      m_valid;
   logic      m_rd_known;
   reg_data_t m_rd1;
   reg_data_t m_rd2;
   reg_addr_t m_ha1;
   reg_addr_t m_ha2;
   rsp_t      sb [$];
   vec_t      tbl [7];

   regfile_read_port_if bus ();

   regfile_read_port dut (
      .clk     (clk),
      .reset   (reset),
      .rf_q    (rf_q),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rp      (bus.slave)
   );

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
      assign rf_q[g*DATA_W +: DATA_W] = regs[g];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic reg_data_t sel_model(reg_addr_t a, logic we, reg_addr_t wa, reg_data_t wd);
      if (a == ZERO_ADDR) return '0;
      if (we && wa == a) return wd;
      return regs[a];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock of stimulus: check outputs against the model, advance the model, take the edge.
   task automatic applyStimulus(input logic rv, input reg_addr_t a1, input reg_addr_t a2,
                                input logic we, input reg_addr_t wa, input reg_data_t wd,
                                input logic rr, input logic fl, input logic rs);
      rsp_t exp;
      logic acc;
      bus.req_valid = rv;
      bus.ra1       = a1;
      bus.ra2       = a2;
      bus.rsp_ready = rr;
      bus.flush     = fl;
      wr_en         = we;
      wr_addr       = wa;
      wr_data       = wd;
      reset         = rs;
      #3;
      checkOutput("req_ready", 64'(bus.req_ready), 64'(!m_valid || rr));
      checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
      if (m_valid) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL scoreboard: got response expected none");
         end else begin
            checkOutput("sb_rd1", bus.rd1, sb[0].rd1);
            checkOutput("sb_rd2", bus.rd2, sb[0].rd2);
            if (rr) void'(sb.pop_front());
         end
      end else if (m_rd_known) begin
         checkOutput("idle_rd1", bus.rd1, m_rd1);
         checkOutput("idle_rd2", bus.rd2, m_rd2);
      end
      acc = rv && (!m_valid || rr) && !fl;
      if (rs) begin
         m_valid    = 1'b0;
         m_rd1      = '0;
         m_rd2      = '0;
         m_ha1      = '0;
         m_ha2      = '0;
         m_rd_known = 1'b1;
         sb.delete();
      end else if (fl) begin
         if (m_valid && !rr) sb.delete();
         m_valid    = 1'b0;
         m_rd_known = 1'b0;
      end else if (acc) begin
         exp.rd1    = sel_model(a1, we, wa, wd);
         exp.rd2    = sel_model(a2, we, wa, wd);
         sb.push_back(exp);
         m_valid    = 1'b1;
         m_rd1      = exp.rd1;
         m_rd2      = exp.rd2;
         m_ha1      = a1;
         m_ha2      = a2;
         m_rd_known = 1'b1;
      end else if (m_valid && rr) begin
         m_valid = 1'b0;
      end else if (m_valid && HOLD_BYPASS && sb.size() > 0) begin
         if (we && wa == m_ha1 && wa != ZERO_ADDR) begin
            m_rd1     = wd;
            sb[0].rd1 = wd;
         end
         if (we && wa == m_ha2 && wa != ZERO_ADDR) begin
            m_rd2     = wd;
            sb[0].rd2 = wd;
         end
      end
      @(posedge clk);
      #1;
      if (we && wa != ZERO_ADDR) regs[wa] = wd;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      m_valid    = 1'b0;
      m_rd_known = 1'b1;
      m_rd1      = '0;
      m_rd2      = '0;
      m_ha1      = '0;
      m_ha2      = '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] = 64'h1000 + 64'(i);
      regs[3] = 64'hA5;
      regs[7] = 64'h3C;

      tbl[0] = '{a1: 5'd3,  a2: 5'd7,  we: 1'b0, wa: 5'd0,  wd: 64'h0,                   e1: 64'hA5,                 e2: 64'h3C};
      tbl[1] = '{a1: 5'd31, a2: 5'd5,  we: 1'b1, wa: 5'd5,  wd: 64'h1234,                e1: 64'h0,                  e2: 64'h1234};
      tbl[2] = '{a1: 5'd31, a2: 5'd31, we: 1'b1, wa: 5'd31, wd: 64'hFF,                  e1: 64'h0,                  e2: 64'h0};
      tbl[3] = '{a1: 5'd5,  a2: 5'd5,  we: 1'b0, wa: 5'd0,  wd: 64'h0,                   e1: 64'h1234,               e2: 64'h1234};
      tbl[4] = '{a1: 5'd0,  a2: 5'd30, we: 1'b0, wa: 5'd0,  wd: 64'h0,                   e1: 64'h1000,               e2: 64'h101E};
      tbl[5] = '{a1: 5'd9,  a2: 5'd3,  we: 1'b1, wa: 5'd3,  wd: 64'hDEADBEEF_CAFEF00D,   e1: 64'h1009,               e2: 64'hDEADBEEF_CAFEF00D};
      tbl[6] = '{a1: 5'd3,  a2: 5'd9,  we: 1'b1, wa: 5'd9,  wd: 64'h77,                  e1: 64'hDEADBEEF_CAFEF00D,  e2: 64'h77};

      bus.req_valid = 1'b0;
      bus.ra1       = '0;
      bus.ra2       = '0;
      bus.rsp_ready = 1'b0;
      bus.flush     = 1'b0;
      wr_en         = 1'b0;
      wr_addr       = '0;
      wr_data       = '0;
      reset         = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #3;
      checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("reset_rd1", bus.rd1, 64'd0);
      checkOutput("reset_rd2", bus.rd2, 64'd0);
      checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1;

      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b1, tbl[k].a1, tbl[k].a2, tbl[k].we, tbl[k].wa, tbl[k].wd, 1'b1, 1'b0, 1'b0);
         checkOutput("tbl_valid", 64'(bus.rsp_valid), 64'd1);
         checkOutput("tbl_rd1", bus.rd1, tbl[k].e1);
         checkOutput("tbl_rd2", bus.rd2, tbl[k].e2);
      end
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Stall with a pending request, then drain and accept in the same cycle.
      applyStimulus(1'b1, 5'd10, 5'd11, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b1, 5'd12, 5'd13, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_req_ready", 64'(bus.req_ready), 64'd0);
      checkOutput("stall_rd1", bus.rd1, 64'h100A);
      checkOutput("stall_rd2", bus.rd2, 64'h100B);
      applyStimulus(1'b1, 5'd12, 5'd13, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("b2b_valid", 64'(bus.rsp_valid), 64'd1);
      checkOutput("b2b_rd1", bus.rd1, 64'h100C);
      checkOutput("b2b_rd2", bus.rd2, 64'h100D);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Write to a held source register while stalled.
      applyStimulus(1'b1, 5'd4, 5'd6, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 64'h99, 1'b0, 1'b0, 1'b0);
      checkOutput("hold_rd1", bus.rd1, HOLD_BYPASS ? 64'h99 : 64'h1004);
      checkOutput("hold_rd2", bus.rd2, 64'h1006);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Flush beats accept, and drops a stalled response.
      applyStimulus(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1, 1'b0);
      checkOutput("flush_acc_valid", 64'(bus.rsp_valid), 64'd0);
      applyStimulus(1'b1, 5'd2, 5'd2, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("flush_stall_valid", 64'(bus.rsp_valid), 64'd0);

      // Reset mid-stall, then reset together with flush and a request.
      applyStimulus(1'b1, 5'd8, 5'd9, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("rst_stall_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("rst_stall_rd1", bus.rd1, 64'd0);
      checkOutput("rst_stall_rd2", bus.rd2, 64'd0);
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b1);
      checkOutput("rst_flush_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("rst_flush_rd1", bus.rd1, 64'd0);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
